// File: rtl/rng_pkg.sv
// Shared constants and helpers for the RNG post-processing block.
package rng_pkg;

    localparam int ROT_Y             = 11;
    localparam int ROT_Z             = 21;
    localparam int DECIM_DEFAULT     = 8;
    localparam int DEPTH_DEFAULT     = 4;
    localparam int REP_LIMIT_DEFAULT = 4;
    localparam int DROP_CNT_W        = 16;

    typedef logic [31:0] word_t;

    // 32-bit rotate-left; n is a small constant in every use.
    function automatic word_t rotl32(input word_t v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

endpackage

// File: rtl/rng_fifo.sv
// Power-of-two FIFO with occupancy count; rdata_o reads 0 while empty.
module rng_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level == (AW+1)'(DEPTH));
    assign empty_o = (level == '0);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values.
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        // NOTE: the array is deliberately not reset; level gates every read, so stale words are never visible.
        if (do_push) mem[wr_ptr] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem[rd_ptr];
    assign level_o = level;

endmodule

// File: rtl/rng_postproc.sv
// Decimates a chaotic generator's state into whitened 32-bit words,
// runs a repetition health test and buffers accepted words in a FIFO.
module rng_postproc
    import rng_pkg::*;
#(
    parameter int DECIM     = DECIM_DEFAULT,
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int REP_LIMIT = REP_LIMIT_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic [31:0]             x_i,
    input  logic [31:0]             y_i,
    input  logic [31:0]             z_i,
    output logic [31:0]             data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    fail_o,
    output logic                    overflow_o,
    output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

    localparam int CNT_W = $clog2(DECIM);
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    logic [CNT_W-1:0] cnt;
    logic             strobe;
    word_t            raw;
    word_t            prev_raw;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_next;
    logic             trip;
    logic             accept;
    logic             pop;
    logic             push;
    logic             drop;
    logic             full;
    logic             empty;

    assign strobe = en_i && (cnt == CNT_W'(DECIM - 1));
    assign raw    = x_i ^ rotl32(y_i, ROT_Y) ^ rotl32(z_i, ROT_Z);

    // Sample-period counter: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DECIM - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next repetition count for the current raw word, saturating at REP_LIMIT.
    always_comb begin
        // NOTE: default assigned first so no path leaves rep_next unassigned (no latch).
        rep_next = REP_W'(1);
        if (raw == prev_raw) begin
            rep_next = (rep_cnt == REP_W'(REP_LIMIT)) ? rep_cnt : rep_cnt + 1'b1;
        end
    end

    // The tripping sample and everything after it stay out of the FIFO.
    assign trip   = strobe && (rep_next == REP_W'(REP_LIMIT));
    assign accept = strobe && !fail_o && !trip;
    assign pop    = valid_o && ready_i;
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    // Health test state, sticky flags and saturating drop counter; clr_i wins over sets.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_raw   <= '0;
            rep_cnt    <= '0;
            fail_o     <= 1'b0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            if (strobe) begin
                prev_raw <= raw;
                rep_cnt  <= rep_next;
            end
            if (trip) fail_o <= 1'b1;
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
            end
            if (clr_i) begin
                fail_o     <= 1'b0;
                overflow_o <= 1'b0;
                rep_cnt    <= '0;
            end
        end
    end

    rng_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (raw ^ prev_raw),
        .rdata_o (data_o),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    assign valid_o = !empty;

endmodule

// File: tb/tb_rng_postproc.sv
// Self-checking bench for rng_postproc: directed scenarios plus a randomized
// run compared every cycle against a queue-based reference model.
module tb_rng_postproc;

    localparam int DECIM     = 8;
    localparam int DEPTH     = 4;
    localparam int REP_LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [31:0] x_i = '0;
    logic [31:0] y_i = '0;
    logic [31:0] z_i = '0;
    logic [31:0] data_o;
    logic        valid_o;
    logic [2:0]  level_o;
    logic        fail_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int          m_cnt  = 0;
    logic [31:0] m_prev = '0;
    int          m_rep  = 0;
    bit          m_fail = 1'b0;
    bit          m_ovf  = 1'b0;
    int          m_drop = 0;
    logic [31:0] m_q[$];

    rng_postproc #(
        .DECIM     (DECIM),
        .DEPTH     (DEPTH),
        .REP_LIMIT (REP_LIMIT)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .clr_i      (clr_i),
        .x_i        (x_i),
        .y_i        (y_i),
        .z_i        (z_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .level_o    (level_o),
        .fail_o     (fail_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rot_left(input logic [31:0] v, input int n);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[(i + n) % 32] = v[i];
        return r;
    endfunction

    function automatic logic [31:0] ref_raw(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] z);
        return x ^ rot_left(y, 11) ^ rot_left(z, 21);
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_tick();
        bit          strobe;
        bit          pop;
        bit          was_full;
        bit          trip;
        logic [31:0] raw;
        if (!rst_ni) begin
            m_cnt = 0; m_prev = '0; m_rep = 0;
            m_fail = 1'b0; m_ovf = 1'b0; m_drop = 0;
            m_q.delete();
            return;
        end
        strobe   = en_i && (m_cnt == DECIM - 1);
        m_cnt    = en_i ? (m_cnt + 1) % DECIM : 0;
        was_full = (m_q.size() == DEPTH);
        pop      = (m_q.size() > 0) && ready_i;
        trip     = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (strobe) begin
            raw   = ref_raw(x_i, y_i, z_i);
            m_rep = (raw == m_prev) ? ((m_rep + 1 > REP_LIMIT) ? REP_LIMIT : m_rep + 1) : 1;
            trip  = (m_rep == REP_LIMIT);
            if (!m_fail && !trip) begin
                if (!was_full || pop) begin
                    m_q.push_back(raw ^ m_prev);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
            m_prev = raw;
        end
        if (trip) m_fail = 1'b1;
        if (clr_i) begin
            m_fail = 1'b0; m_ovf = 1'b0; m_rep = 0;
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; en_i = 1'b0; clr_i = 1'b0; ready_i = 1'b0;
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        steps(2);
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_o); end
        n_checks++; if (level_o !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level_o); end
        n_checks++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b want 0", fail_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        n_checks++; if (drop_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
        rst_ni = 1'b1;
    endtask

    task automatic test_first_word();
        do_reset();
        x_i = 32'h1; y_i = '0; z_i = '0; en_i = 1'b1;
        steps(7);
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL first_early_valid: got %b want 0", valid_o); end
        step();
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", valid_o); end
        n_checks++; if (data_o !== 32'h1) begin n_fail++; $display("FAIL first_data: got %h want 00000001", data_o); end
        steps(7);
        n_checks++; if (level_o !== 3'd1) begin n_fail++; $display("FAIL first_hold_level: got %0d want 1", level_o); end
        step();
        n_checks++; if (level_o !== 3'd2) begin n_fail++; $display("FAIL second_level: got %0d want 2", level_o); end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL second_data: got %h want 00000000", data_o); end
        n_checks++; if (level_o !== 3'd1) begin n_fail++; $display("FAIL after_pop_level: got %0d want 1", level_o); end
        en_i = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        y_i = '0; z_i = '0; ready_i = 1'b0; en_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            x_i = 32'h100 + 32'(k);
            step();
        end
        n_checks++; if (level_o !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", level_o); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
        n_checks++; if (drop_cnt_o !== 16'd1) begin n_fail++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt_o); end
        n_checks++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL ovf_fail: got %b want 0", fail_o); end
        n_checks++; if (data_o !== m_q[0]) begin n_fail++; $display("FAIL ovf_head: got %h want %h", data_o, m_q[0]); end
    endtask

    // Continues from the full FIFO left by test_overflow.
    task automatic test_full_push_pop();
        for (int k = 0; k < 7; k++) begin
            x_i = 32'h200 + 32'(k);
            step();
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        n_checks++; if (level_o !== 3'd4) begin n_fail++; $display("FAIL pp_level: got %0d want 4", level_o); end
        n_checks++; if (drop_cnt_o !== 16'd1) begin n_fail++; $display("FAIL pp_drop: got %0d want 1", drop_cnt_o); end
        n_checks++; if (data_o !== m_q[0]) begin n_fail++; $display("FAIL pp_head: got %h want %h", data_o, m_q[0]); end
        en_i = 1'b0; clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", overflow_o); end
        n_checks++; if (drop_cnt_o !== 16'd1) begin n_fail++; $display("FAIL clr_drop: got %0d want 1", drop_cnt_o); end
    endtask

    task automatic test_health();
        logic [31:0] raw;
        logic [31:0] exp_words[3];
        do_reset();
        do begin
            x_i = $urandom; y_i = $urandom; z_i = $urandom;
            raw = ref_raw(x_i, y_i, z_i);
        end while (raw == 32'h0);
        exp_words[0] = raw; exp_words[1] = 32'h0; exp_words[2] = 32'h0;
        ready_i = 1'b0; en_i = 1'b1;
        steps(24);
        n_checks++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL health_early: got %b want 0", fail_o); end
        n_checks++; if (level_o !== 3'd3) begin n_fail++; $display("FAIL health_level3: got %0d want 3", level_o); end
        steps(8);
        n_checks++; if (fail_o !== 1'b1) begin n_fail++; $display("FAIL health_trip: got %b want 1", fail_o); end
        n_checks++; if (level_o !== 3'd3) begin n_fail++; $display("FAIL health_no_trip_push: got %0d want 3", level_o); end
        steps(16);
        n_checks++; if (level_o !== 3'd3) begin n_fail++; $display("FAIL health_no_more_push: got %0d want 3", level_o); end
        en_i = 1'b0; clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        n_checks++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL health_clr: got %b want 0", fail_o); end
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (data_o !== exp_words[i]) begin
                n_fail++; $display("FAIL health_pop%0d: got %h want %h", i, data_o, exp_words[i]);
            end
            step();
        end
        ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL health_drained: got %b want 0", valid_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        y_i = '0; z_i = '0; ready_i = 1'b0; en_i = 1'b1;
        for (int k = 0; k < 24; k++) begin
            x_i = 32'h300 + 32'(k);
            step();
        end
        n_checks++; if (level_o !== 3'd3) begin n_fail++; $display("FAIL rmid_pre_level: got %0d want 3", level_o); end
        ready_i = 1'b1; rst_ni = 1'b0;
        step();
        rst_ni = 1'b1; ready_i = 1'b0; en_i = 1'b0;
        n_checks++; if (level_o !== 3'd0) begin n_fail++; $display("FAIL rmid_level: got %0d want 0", level_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", valid_o); end
        n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL rmid_data: got %h want 0", data_o); end
        n_checks++; if ({fail_o, overflow_o} !== 2'b00) begin n_fail++; $display("FAIL rmid_flags: got %b want 00", {fail_o, overflow_o}); end
        n_checks++; if (drop_cnt_o !== 16'h0) begin n_fail++; $display("FAIL rmid_drop: got %0d want 0", drop_cnt_o); end
    endtask

    task automatic test_enable_gap();
        do_reset();
        x_i = 32'hA5A5_0001; y_i = '0; z_i = '0; ready_i = 1'b0; en_i = 1'b1;
        steps(5);
        en_i = 1'b0;
        steps(3);
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL gap_no_strobe: got %b want 0", valid_o); end
        en_i = 1'b1;
        steps(7);
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL gap_early: got %b want 0", valid_o); end
        step();
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL gap_strobe: got %b want 1", valid_o); end
        n_checks++; if (data_o !== 32'hA5A5_0001) begin n_fail++; $display("FAIL gap_data: got %h want a5a50001", data_o); end
        en_i = 1'b0;
    endtask

    task automatic test_random();
        bit          hold = 1'b0;
        logic [31:0] exp_data;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en_i    = ($urandom_range(7) != 0);
            ready_i = ($urandom_range(2) == 0);
            clr_i   = ($urandom_range(63) == 0);
            rst_ni  = ($urandom_range(499) != 0);
            if ($urandom_range(15) == 0) hold = ~hold;
            if (!hold) begin
                x_i = $urandom; y_i = $urandom; z_i = $urandom;
            end
            step();
            exp_data = (m_q.size() > 0) ? m_q[0] : 32'h0;
            n_checks++; if (data_o !== exp_data) begin n_fail++; $display("FAIL rnd_data c=%0d: got %h want %h", c, data_o, exp_data); end
            n_checks++; if (valid_o !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, valid_o, m_q.size() > 0); end
            n_checks++; if (level_o !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_level c=%0d: got %0d want %0d", c, level_o, m_q.size()); end
            n_checks++; if (fail_o !== m_fail) begin n_fail++; $display("FAIL rnd_fail c=%0d: got %b want %b", c, fail_o, m_fail); end
            n_checks++; if (overflow_o !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d: got %b want %b", c, overflow_o, m_ovf); end
            n_checks++; if (drop_cnt_o !== 16'(m_drop)) begin n_fail++; $display("FAIL rnd_drop c=%0d: got %0d want %0d", c, drop_cnt_o, m_drop); end
        end
        rst_ni = 1'b1; en_i = 1'b0; clr_i = 1'b0; ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_overflow();
        test_full_push_pop();
        test_health();
        test_reset_mid();
        test_enable_gap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rng_postproc.md
RNG_POSTPROC -- requirements
Module: rng_postproc

Interface
REQ-001 SHALL have parameter DECIM, default 8, meaning the sample period in clk_i cycles (2..256).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the output FIFO entries (power of 2, 2..16).
REQ-003 SHALL have parameter REP_LIMIT, default 4, meaning consecutive identical raw samples that trip the health failure.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port en_i, input, 1 bit: sampling enable.
REQ-007 SHALL have port clr_i, input, 1 bit: clears the sticky fail_o and overflow_o flags.
REQ-008 SHALL have ports x_i, y_i, z_i, input, 32 bits each: chaotic generator state words, valid every cycle.
REQ-009 SHALL have port data_o, output, 32 bits: the head random word.
REQ-010 SHALL have port valid_o, output, 1 bit: data_o holds a word.
REQ-011 SHALL have port ready_i, input, 1 bit: the consumer accepts data_o.
REQ-012 SHALL have port level_o, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-013 SHALL have port fail_o, output, 1 bit: sticky health-test failure.
REQ-014 SHALL have port overflow_o, output, 1 bit: sticky dropped-sample flag.
REQ-015 SHALL have port drop_cnt_o, output, 16 bits: dropped samples, saturating at 16'hFFFF.

Function
REQ-016 SHALL use a decimation counter that increments each cycle while en_i=1, wraps DECIM-1 -> 0, and is forced to 0 while en_i=0.
REQ-017 SHALL assert a sample strobe on every cycle where en_i=1 and the counter equals DECIM-1.
REQ-018 SHALL compute the raw word as raw = x_i ^ rotl(y_i,11) ^ rotl(z_i,21), using 32-bit rotate-left.
REQ-019 SHALL hold prev_raw (reset 0) and update it to raw on each strobe; the whitened word = raw ^ prev_raw.
REQ-020 SHALL update the health test on each strobe: rep_cnt = (raw==prev_raw) ? rep_cnt+1 : 1, saturating at REP_LIMIT; fail_o SHALL set on the edge where rep_cnt reaches REP_LIMIT.
REQ-021 SHALL push the whitened word on a strobe only when fail_o=0 and the push does not overflow; the sample that trips fail_o SHALL NOT be pushed.
REQ-022 SHALL treat a strobe arriving with the FIFO full and no pop in the same cycle as a drop: the word is discarded, overflow_o sets, and drop_cnt_o increments.
REQ-023 SHALL accept the push when the FIFO is full and a pop occurs in the same cycle (level unchanged).
REQ-024 SHALL pop when valid_o=1 and ready_i=1; ready_i SHALL be ignored when valid_o=0.
REQ-025 SHALL drive valid_o = (level_o != 0), and drive data_o = 0 when the FIFO is empty.
REQ-026 SHALL give a pushed word 1-cycle latency: a strobe on cycle t puts the word on data_o with valid_o=1 at t+1 when the FIFO was empty.
REQ-027 SHALL give clr_i priority over a same-cycle set: fail_o and overflow_o clear, rep_cnt resets to 0, and drop_cnt_o is unaffected.
REQ-028 SHALL leave already-stored words poppable after fail_o sets.

Reset
REQ-029 SHALL, on the clk_i edge where rst_ni=0, clear the counter, prev_raw, rep_cnt, FIFO pointers, level_o, fail_o, overflow_o and drop_cnt_o to 0 and discard stored words.
REQ-030 SHALL, in the cycle after reset, drive valid_o=0 and data_o=0; a reset mid-handshake loses the head word with no pop reported.

Structure
REQ-031 SHALL place the rotate amounts (11, 21), the default DECIM/DEPTH/REP_LIMIT and the drop-counter width in a shared package rng_pkg.
REQ-032 SHALL implement the FIFO as sub-module rng_fifo (parameterised width/depth, push/pop/full/empty/level), instantiated once.

Verification
REQ-033 SHALL cover: x=1, y=0, z=0 constant, DECIM=8, en_i=1 -> first strobe at cycle 7, data_o=0x00000001, then the next word 0x00000000 pushed at cycle 15.
REQ-034 SHALL cover: ready_i=0 with 5 strobes at DEPTH=4 -> level_o=4, overflow_o=1, drop_cnt_o=1; fail_o remains 0 only if the raw values differ.
REQ-035 SHALL cover: constant x/y/z for 4 strobes -> fail_o=1 at the 4th strobe, 3 words pushed, no further pushes; clr_i=1 -> fail_o=0.
REQ-036 SHALL cover: FIFO full, ready_i=1 on a strobe cycle -> push and pop both occur, level_o stays 4, drop_cnt_o unchanged.
REQ-037 SHALL cover: rst_ni=0 for 1 cycle with level_o=3 -> next cycle level_o=0, valid_o=0, data_o=0, all flags 0.
REQ-038 SHALL cover: en_i dropped at counter=5, then raised -> next strobe occurs DECIM cycles after en_i rises.
